if_prefetch_buffer: RTL and testbench
=====================================

// Module: if_prefetch_buffer
// PURPOSE
//  Fetch stage that sits directly upstream of the pipelined datapath's IF/ID register.
//  Issues sequential instruction-memory reads and queues returned {pc, instr} pairs in a DEPTH-entry FIFO.
//  Presents the FIFO head to decode with a valid/ready handshake.
//  Discards queued and in-flight fetches on a branch/jump redirect (PcSel) and restarts at the target.
// PARAMETERS
//  PC_W      9   program counter width (byte address)
//  INS_W     32  instruction width
//  DEPTH     4   FIFO entries; power of 2, >=2
//  RESET_PC  0   first fetch address after reset
// PORTS
//  clk          in   1      clock, all state on rising edge
//  reset        in   1      synchronous, active-low; reset==0 clears state at the next edge
//  redirect     in   1      flush + restart request (PcSel from EX)
//  redirect_pc  in   PC_W   restart address, sampled when redirect==1
//  imem_req     out  1      read request to instruction memory
//  imem_addr    out  PC_W   read address, valid while imem_req==1
//  imem_ready   in   1      memory accepts request this cycle
//  imem_rvalid  in   1      read data valid; responses return in order, >=1 cycle after acceptance
//  imem_rdata   in   INS_W  read data
//  if_valid     out  1      FIFO head valid to decode
//  if_ready     in   1      decode takes head this cycle (= !Reg_Stall)
//  if_pc        out  PC_W   PC of head entry
//  if_instr     out  INS_W  instruction of head entry
//  fifo_count   out  $clog2(DEPTH)+1  occupancy, debug
// BEHAVIOUR
//  Reset (reset==0 at an edge): fetch_pc<=RESET_PC; wr_ptr, rd_ptr, count, outstanding and discard<=0.
//   While reset==0: imem_req=0, if_valid=0, if_pc=0, if_instr=0, fifo_count=0.
//   Reset asserted mid-fetch: the pending response is ignored (outstanding cleared) and never enters the FIFO.
//  Request: imem_req = reset & !redirect & (!outstanding | imem_rvalid) & (count + outstanding < DEPTH).
//   imem_addr = fetch_pc.
//   Accept = imem_req & imem_ready: outstanding<=1, req_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (mod 2^PC_W).
//   At most one request in flight. With a 1-cycle memory, back-to-back accepts sustain 1 instr/cycle.
//  Response: imem_rvalid with outstanding==1 clears outstanding unless a new accept occurs in the same cycle.
//   If discard==0: push {req_pc, imem_rdata} at wr_ptr. If discard==1: drop the data and clear discard.
//   imem_rvalid with outstanding==0 is ignored.
//  Pop: if_valid = (count!=0) & !redirect. Pop when if_valid & if_ready; rd_ptr advances.
//   if_pc/if_instr come from the head entry register. Pointers wrap mod DEPTH.
//  Simultaneous push and pop: count unchanged, both pointers advance.
//   Full FIFO cannot be pushed, because the credit rule reserves a slot for every outstanding request.
//  Redirect (redirect==1 at an edge, reset==1): count, wr_ptr, rd_ptr<=0; fetch_pc<=redirect_pc; imem_req=0 this cycle.
//   Response arriving in that cycle is dropped.
//   If a request remains outstanding past the edge: discard<=1, and its later response is dropped.
//   The first request to redirect_pc is issued the next cycle, subject to the in-flight rule.
//   Redirect has priority over push, pop and accept.
//  Latency: reset release at edge E -> req@RESET_PC in cycle E. With a 1-cycle memory, rvalid in E+1 and if_valid in E+2.
//   Redirect at edge R -> if_valid for the target no earlier than R+2.
//  redirect_pc is used unaligned as given. PC_W overflow wraps silently.
// TESTING
//  1. Reset release, 1-cycle memory, if_ready=1 -> if_pc=0,4,8,12 on consecutive cycles from E+2; instr matches memory.
//  2. if_ready=0 for 10 cycles -> fifo_count reaches 4 and holds; imem_req=0 while count+outstanding==4; order is kept on release.
//  3. redirect=1, redirect_pc=0x40, with a fetch in flight and 3 entries queued -> late response dropped; next if_pc=0x40, no stale PCs.
//  4. imem_ready=0 for 3 cycles, memory latency 3 -> imem_addr held stable; no duplicate or skipped PC in the if_pc sequence.
//  5. fetch_pc=0x1FC (PC_W=9) -> next fetch address wraps to 0x000.
//  6. reset=0 for one cycle mid-stream with a request outstanding -> if_valid=0 next cycle; the response is not queued; restart at RESET_PC.

Source files
------------

// File: rtl/if_prefetch_buffer.sv
// if_prefetch_buffer: sequential instruction prefetch into a small {pc, instr} FIFO feeding IF/ID,
// with a redirect that flushes queued entries and drops the response of any fetch already in flight.
module if_prefetch_buffer #(
    parameter int PC_W = 9,
    parameter int INS_W = 32,
    parameter int DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     redirect,
    input  logic [PC_W-1:0]          redirect_pc,
    output logic                     imem_req,
    output logic [PC_W-1:0]          imem_addr,
    input  logic                     imem_ready,
    input  logic                     imem_rvalid,
    input  logic [INS_W-1:0]         imem_rdata,
    output logic                     if_valid,
    input  logic                     if_ready,
    output logic [PC_W-1:0]          if_pc,
    output logic [INS_W-1:0]         if_instr,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(DEPTH);
    logic [PC_W-1:0]  fetch_pc, req_pc;
    logic             outstanding, discard;
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic [PC_W-1:0]  pc_q [DEPTH];
    logic [INS_W-1:0] ins_q [DEPTH];
    logic             rsp, push, pop, accept, credit;
    // every in-flight request owns a FIFO slot, so a response can always be pushed
    assign credit     = ({1'b0, count} + (AW+2)'(outstanding)) < (AW+2)'(DEPTH);
    assign imem_req   = reset & ~redirect & (~outstanding | imem_rvalid) & credit;
    assign imem_addr  = fetch_pc;
    assign accept     = imem_req & imem_ready;
    assign rsp        = imem_rvalid & outstanding;
    assign push       = rsp & ~discard & ~redirect & reset;
    assign if_valid   = reset & ~redirect & (count != '0);
    assign pop        = if_valid & if_ready;
    assign if_pc      = reset ? pc_q[rd_ptr] : '0;
    assign if_instr   = reset ? ins_q[rd_ptr] : '0;
    assign fifo_count = reset ? count : '0;
    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc    <= RESET_PC;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            outstanding <= 1'b0;
            discard     <= 1'b0;
        end else if (redirect) begin
            fetch_pc    <= redirect_pc;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            outstanding <= outstanding & ~imem_rvalid;
            discard     <= outstanding & ~imem_rvalid;
        end else begin
            if (accept) begin
                fetch_pc <= fetch_pc + PC_W'(4);
                req_pc   <= fetch_pc;
            end
            outstanding <= accept | (outstanding & ~imem_rvalid);
            if (rsp) discard <= 1'b0;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push) begin
            pc_q[wr_ptr]  <= req_pc;
            ins_q[wr_ptr] <= imem_rdata;
        end
    end
endmodule

// File: tb/tb_if_prefetch_buffer.sv
// tb_if_prefetch_buffer: randomized bench; the reference model tracks fetch streams by epoch and
// keeps the expected FIFO contents as a queue of PCs.
module tb_if_prefetch_buffer;
    localparam int PC_W = 9, INS_W = 32, DEPTH = 4, CW = 3;
    logic clk = 0, reset = 0, redirect = 0;
    logic [PC_W-1:0] redirect_pc = '0;
    logic imem_req, imem_ready = 0, imem_rvalid = 0;
    logic [PC_W-1:0] imem_addr;
    logic [INS_W-1:0] imem_rdata = '0;
    logic if_valid, if_ready = 0;
    logic [PC_W-1:0] if_pc;
    logic [INS_W-1:0] if_instr;
    logic [CW-1:0] fifo_count;

    always #5 clk = ~clk;

    if_prefetch_buffer #(.PC_W(PC_W), .INS_W(INS_W), .DEPTH(DEPTH), .RESET_PC('0)) dut (
        .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .if_valid(if_valid),
        .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr), .fifo_count(fifo_count)
    );

    int checks = 0, errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [PC_W-1:0] a);
        return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A_C3C3;
    endfunction

    // reference model state
    logic [PC_W-1:0] mq[$];
    logic [PC_W-1:0] exp_fetch = '0, busy_addr = '0;
    bit busy = 0;
    int lat_left = 0, epoch = 0, busy_epoch = 0;
    int p_ready = 100, p_ifr = 100, max_lat = 1;
    logic last_valid, last_req;
    logic [PC_W-1:0] last_pc, last_addr, prev_pop;
    bit wrap_seen = 0;

    task automatic cycle(input bit rst_v, input bit redir, input logic [PC_W-1:0] rpc);
        bit acc, pop, resp, exp_req;
        logic [PC_W-1:0] r_addr;
        int r_epoch;
        @(negedge clk);
        reset = rst_v;
        redirect = redir;
        redirect_pc = rpc;
        imem_rvalid = busy && lat_left == 0;
        imem_rdata = imem_rvalid ? mem_word(busy_addr) : $urandom;
        imem_ready = $urandom_range(99) < p_ready;
        if_ready = $urandom_range(99) < p_ifr;
        #1;
        exp_req = reset && !redirect && (!busy || imem_rvalid) && (mq.size() + int'(busy) < DEPTH);
        check("imem_req", imem_req, exp_req);
        check("if_valid", if_valid, reset && !redirect && mq.size() != 0);
        check("fifo_count", fifo_count, reset ? mq.size() : 0);
        if (imem_req) check("imem_addr", imem_addr, exp_fetch);
        if (if_valid && mq.size() != 0) begin
            check("if_pc", if_pc, mq[0]);
            check("if_instr", if_instr, mem_word(mq[0]));
        end
        if (!reset) begin
            check("rst_if_pc", if_pc, 0);
            check("rst_if_instr", if_instr, 0);
        end
        last_valid = if_valid; last_pc = if_pc; last_req = imem_req; last_addr = imem_addr;
        acc = imem_req && imem_ready;
        pop = if_valid && if_ready;
        resp = imem_rvalid;
        r_addr = busy_addr;
        r_epoch = busy_epoch;
        @(posedge clk);
        if (resp) busy = 0;
        else if (busy && lat_left > 0) lat_left--;
        if (!reset) begin
            mq.delete(); busy = 0; exp_fetch = '0; epoch++;
        end else if (redirect) begin
            mq.delete(); exp_fetch = rpc; epoch++;
        end else begin
            if (pop) begin
                if (prev_pop == 9'h1FC && mq[0] == 9'h000) wrap_seen = 1;
                prev_pop = mq[0];
                void'(mq.pop_front());
            end
            if (resp && r_epoch == epoch) mq.push_back(r_addr);
            if (acc) begin
                busy = 1; busy_addr = exp_fetch; busy_epoch = epoch;
                lat_left = $urandom_range(max_lat, 1) - 1;
                exp_fetch = exp_fetch + 9'd4;
            end
        end
    endtask

    logic v[6];
    logic [PC_W-1:0] p[6];
    logic [PC_W-1:0] a0;
    int n;

    initial begin
        // 1: reset release with a 1-cycle memory and decode always ready
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            cycle(1, 0, 0);
            v[i] = last_valid; p[i] = last_pc;
            if (i == 0) begin
                check("t1_req_e", last_req, 1);
                check("t1_addr_e", last_addr, 0);
            end
        end
        check("t1_valid_e", v[0], 0);
        check("t1_valid_e1", v[1], 0);
        for (int i = 2; i < 6; i++) begin
            check("t1_valid", v[i], 1);
            check("t1_pc", p[i], 9'((i - 2) * 4));
        end
        // 2: decode stalled for 10 cycles fills the FIFO and stops requests
        p_ifr = 0;
        for (int i = 0; i < 10; i++) cycle(1, 0, 0);
        check("t2_count_full", fifo_count, 4);
        check("t2_req_blocked", last_req, 0);
        p_ifr = 100;
        for (int i = 0; i < 8; i++) cycle(1, 0, 0);
        // 3: redirect with three queued and one in flight
        p_ifr = 0;
        n = 0;
        while (!(mq.size() == 3 && busy) && n < 20) begin cycle(1, 0, 0); n++; end
        check("t3_setup", n < 20, 1);
        cycle(1, 1, 9'h040);
        p_ifr = 100;
        cycle(1, 0, 0);
        check("t3_no_valid_r1", last_valid, 0);
        n = 0;
        while (!last_valid && n < 10) begin cycle(1, 0, 0); n++; end
        check("t3_valid_seen", last_valid, 1);
        check("t3_first_pc", last_pc, 9'h040);
        // 4: memory stalls then slow responses
        max_lat = 3;
        p_ready = 0;
        cycle(1, 0, 0);
        a0 = last_addr;
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 0);
            if (last_req) check("t4_addr_hold", last_addr, a0);
        end
        p_ready = 100;
        for (int i = 0; i < 20; i++) cycle(1, 0, 0);
        // 5: fetch address wraps past the top of the PC space
        max_lat = 1;
        cycle(1, 1, 9'h1F8);
        for (int i = 0; i < 10; i++) cycle(1, 0, 0);
        check("t5_wrap_seen", wrap_seen, 1);
        // 6: one-cycle reset with a request outstanding
        n = 0;
        while (!busy && n < 10) begin cycle(1, 0, 0); n++; end
        check("t6_setup", busy, 1);
        cycle(0, 0, 0);
        cycle(1, 0, 0);
        check("t6_valid_after", last_valid, 0);
        check("t6_restart_addr", last_addr, 0);
        // random mix
        max_lat = 3; p_ready = 60; p_ifr = 60;
        for (int i = 0; i < 500; i++)
            cycle(1, $urandom_range(99) < 4, 9'($urandom));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
